// File: rtl/conv_mac_pipe_if.sv
// -----------------------------------------------------------------------------
// conv_mac_pipe_if
// Handshake and data bundle for conv_mac_pipe.
//
// Signals:
//   in_valid  : producer has a window/kernel beat on win/ker
//   in_ready  : block accepts the beat this cycle
//   win       : K*K signed pixels, element r*K+c at [(r*K+c)*WIDTH +: WIDTH]
//   ker       : K*K signed weights, same packing as win
//   out_valid : out_data holds a completed multi-channel result
//   out_ready : consumer takes out_data this cycle
//   out_data  : signed accumulated result, ACC_W bits
//
// Modports:
//   master : producer/consumer side (drives inputs, reads results)
//   slave  : conv_mac_pipe side
// -----------------------------------------------------------------------------
interface conv_mac_pipe_if #(
  parameter int WIDTH = 9,
  parameter int K     = 3,
  parameter int ACC_W = 24
);
  logic                     in_valid;
  logic                     in_ready;
  logic [K*K*WIDTH-1:0]     win;
  logic [K*K*WIDTH-1:0]     ker;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [ACC_W-1:0]  out_data;

  modport master (
    output in_valid, win, ker, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, win, ker, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/conv_mac_pipe.sv
// -----------------------------------------------------------------------------
// conv_mac_pipe
// Three-stage pipelined convolution MAC. Each accepted beat carries one
// channel's K*K pixel window and K*K kernel weights. The block forms the
// window dot product and accumulates CH consecutive channel beats into one
// signed result.
//
//   stage 1 : K*K signed products, registered with a valid bit and channel tag
//   stage 2 : sign-extended sum of the products at ACC_W bits
//   stage 3 : tag 0 loads the accumulator, other tags add to it; the last
//             channel (tag CH-1) writes the final sum to out_data/out_valid
//
// Back-pressure: stall = out_valid && !out_ready freezes every register in
// the block; in_ready is simply !stall.
//
// Ports:
//   clk : clock, rising edge
//   rst : asynchronous, active-high reset
//   bus : conv_mac_pipe_if.slave (in_valid/in_ready/win/ker,
//                                 out_valid/out_ready/out_data)
//
// Parameters:
//   WIDTH : pixel/weight width (signed)
//   K     : kernel side
//   CH    : channels per result (>= 1)
//   ACC_W : result width; default is wide enough that nothing can overflow
//
// Build option:
//   CONV_MAC_RELU_EN : when defined, a negative final sum is written as 0.
//                      Undefined (default), the final sum is written signed
//                      and unmodified.
// -----------------------------------------------------------------------------
module conv_mac_pipe #(
  parameter int WIDTH = 9,
  parameter int K     = 3,
  parameter int CH    = 4,
  parameter int ACC_W = 2*WIDTH + $clog2(K*K*CH)
) (
  input  logic          clk,
  input  logic          rst,
  conv_mac_pipe_if.slave bus
);

  localparam int N  = K*K;
  localparam int PW = 2*WIDTH;
  localparam int CW = (CH > 1) ? $clog2(CH) : 1;

  localparam logic [CW-1:0] LAST_TAG = CW'(CH-1);

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  logic w_stall;
  logic w_accept;

  assign w_stall      = bus.out_valid && !bus.out_ready;
  assign bus.in_ready = !w_stall;
  assign w_accept     = bus.in_valid && !w_stall;

  // ---------------------------------------------------------------------------
  // Element products (combinational, from the incoming beat)
  // ---------------------------------------------------------------------------
  logic signed [WIDTH-1:0] w_pix  [N];
  logic signed [WIDTH-1:0] w_wt   [N];
  logic signed [PW-1:0]    w_prod [N];

  always_comb begin
    for (int i = 0; i < N; i++) begin
      w_pix[i]  = bus.win[i*WIDTH +: WIDTH];
      w_wt[i]   = bus.ker[i*WIDTH +: WIDTH];
      // Both operands are widened signed before multiplying so the full
      // 2*WIDTH product is kept.
      w_prod[i] = PW'(w_pix[i]) * PW'(w_wt[i]);
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1 registers
  // ---------------------------------------------------------------------------
  logic signed [PW-1:0] r_s1_prod [N];
  logic                 r_s1_valid;
  logic [CW-1:0]        r_s1_tag;

  // NOTE: the product array is a data-only register bank qualified by
  // r_s1_valid, so it carries no reset; only control state is reset.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      for (int i = 0; i < N; i++) begin
        r_s1_prod[i] <= w_prod[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1 -> stage 2 adder tree (sign-extended to ACC_W)
  // ---------------------------------------------------------------------------
  logic signed [ACC_W-1:0] w_s1_sum;

  // NOTE: every always_comb output gets a default before any loop or branch,
  // so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_s1_sum = '0;
    for (int i = 0; i < N; i++) begin
      w_s1_sum = w_s1_sum + ACC_W'(r_s1_prod[i]);
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2 / stage 3 state
  // ---------------------------------------------------------------------------
  logic signed [ACC_W-1:0] r_s2_sum;
  logic                    r_s2_valid;
  logic [CW-1:0]           r_s2_tag;

  logic [CW-1:0]           r_cnt;
  logic signed [ACC_W-1:0] r_acc;
  logic                    r_out_valid;
  logic signed [ACC_W-1:0] r_out_data;

  logic [CW-1:0]           w_cnt_next;
  logic signed [ACC_W-1:0] w_acc_next;
  logic signed [ACC_W-1:0] w_final;
  logic                    w_result;

  always_comb begin
    w_cnt_next = (r_cnt == LAST_TAG) ? '0 : r_cnt + CW'(1);

    // Tag 0 starts a new channel group, discarding whatever acc held.
    w_acc_next = (r_s2_tag == '0) ? r_s2_sum : r_acc + r_s2_sum;

`ifdef CONV_MAC_RELU_EN
    w_final = w_acc_next[ACC_W-1] ? '0 : w_acc_next;
`else
    w_final = w_acc_next;
`endif

    w_result = r_s2_valid && (r_s2_tag == LAST_TAG);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid  <= 1'b0;
      r_s1_tag    <= '0;
      r_s2_valid  <= 1'b0;
      r_s2_tag    <= '0;
      r_s2_sum    <= '0;
      r_cnt       <= '0;
      r_acc       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else if (!w_stall) begin
      // Stage 1 control: an idle cycle enters as an invalid bubble.
      r_s1_valid <= bus.in_valid;
      r_s1_tag   <= r_cnt;
      if (w_accept) begin
        r_cnt <= w_cnt_next;
      end

      // Stage 2
      r_s2_valid <= r_s1_valid;
      r_s2_tag   <= r_s1_tag;
      r_s2_sum   <= w_s1_sum;

      // Stage 3: bubbles leave the accumulator untouched.
      if (r_s2_valid) begin
        r_acc <= w_acc_next;
      end

      // Output register. Outside a stall either out_valid is already low or
      // out_ready is high, so a cycle without a new result always drains it.
      if (w_result) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_final;
      end else if (bus.out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;

endmodule

// File: tb/tb_conv_mac_pipe.sv
// -----------------------------------------------------------------------------
// tb_conv_mac_pipe
// Directed self-checking bench for conv_mac_pipe at default parameters
// (WIDTH=9, K=3, CH=4, ACC_W=24). Inputs change on the falling edge; a
// monitor samples 2 time units after each falling edge, when every signal is
// stable ahead of the next rising edge.
// -----------------------------------------------------------------------------
module tb_conv_mac_pipe;

  localparam int WIDTH = 9;
  localparam int K     = 3;
  localparam int CH    = 4;
  localparam int ACC_W = 24;
  localparam int N     = K*K;

  typedef logic [N*WIDTH-1:0] vec_t;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  conv_mac_pipe_if #(.WIDTH(WIDTH), .K(K), .ACC_W(ACC_W)) bus ();

  conv_mac_pipe #(
    .WIDTH (WIDTH),
    .K     (K),
    .CH    (CH),
    .ACC_W (ACC_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Vector builders
  // ---------------------------------------------------------------------------
  function automatic vec_t ramp();
    vec_t v;
    v = '0;
    for (int i = 0; i < N; i++) v[i*WIDTH +: WIDTH] = WIDTH'(i);
    return v;
  endfunction

  function automatic vec_t fill(input int val);
    vec_t v;
    v = '0;
    for (int i = 0; i < N; i++) v[i*WIDTH +: WIDTH] = WIDTH'(val);
    return v;
  endfunction

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  int     cyc = 0;
  longint res_q[$];
  int     res_cyc[$];
  int     acc_cyc[$];
  int     valid_cycles;
  int     stall_cycles;
  int     ir_err;
  int     stable_err;
  logic   prev_stall;
  logic   prev_valid;
  logic   prev_consumed;
  logic signed [ACC_W-1:0] prev_data;

  task automatic clear_mon();
    res_q.delete();
    res_cyc.delete();
    acc_cyc.delete();
    valid_cycles = 0;
    stall_cycles = 0;
    ir_err       = 0;
    stable_err   = 0;
  endtask

  initial begin
    prev_stall    = 1'b0;
    prev_valid    = 1'b0;
    prev_consumed = 1'b0;
    prev_data     = '0;
    forever begin
      @(negedge clk);
      #2;
      cyc++;
      if (rst) begin
        prev_stall    = 1'b0;
        prev_valid    = 1'b0;
        prev_consumed = 1'b0;
      end else begin
        if (bus.in_valid && bus.in_ready) acc_cyc.push_back(cyc);
        if (bus.out_valid) valid_cycles++;
        if (bus.out_valid && (!prev_valid || prev_consumed)) res_cyc.push_back(cyc);
        if (prev_stall && (!bus.out_valid || bus.out_data !== prev_data)) stable_err++;
        if (bus.out_valid && !bus.out_ready) begin
          stall_cycles++;
          if (bus.in_ready) ir_err++;
        end
        if (bus.out_valid && bus.out_ready) res_q.push_back(longint'(bus.out_data));
        prev_stall    = bus.out_valid && !bus.out_ready;
        prev_valid    = bus.out_valid;
        prev_consumed = bus.out_valid && bus.out_ready;
        prev_data     = bus.out_data;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (entered and left at a falling edge)
  // ---------------------------------------------------------------------------
  task automatic send_beat(input vec_t w, input vec_t k);
    int n;
    bus.win      = w;
    bus.ker      = k;
    bus.in_valid = 1'b1;
    #1;
    n = 0;
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 100) check("in_ready_timeout", longint'(bus.in_ready), 1);
    @(negedge clk);
  endtask

  task automatic run_group(input vec_t w, input vec_t k, input bit gap);
    for (int b = 0; b < CH; b++) begin
      send_beat(w, k);
      if (gap) begin
        bus.in_valid = 1'b0;
        @(negedge clk);
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    repeat (12) @(negedge clk);
  endtask

  function automatic longint first_res();
    return (res_q.size() > 0) ? res_q[0] : -1;
  endfunction

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  longint exp_neg72;
  longint exp_min;

  initial begin
`ifdef CONV_MAC_RELU_EN
    exp_neg72 = 0;
    exp_min   = 0;
`else
    exp_neg72 = -72;
    exp_min   = -2350080;
`endif

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.win       = '0;
    bus.ker       = '0;
    bus.out_ready = 1'b1;

    // Reset state
    #1;
    check("rst_out_valid", longint'(bus.out_valid), 0);
    check("rst_out_data",  longint'(bus.out_data), 0);
    check("rst_in_ready",  longint'(bus.in_ready), 1);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Basic group: 4 x 204 = 816, one valid cycle, 3 edges incl. acceptance
    clear_mon();
    run_group(ramp(), ramp(), 1'b0);
    drain();
    check("t1_count", res_q.size(), 1);
    check("t1_data", first_res(), 816);
    check("t1_valid_cycles", valid_cycles, 1);
    check("t1_latency",
          (res_cyc.size() > 0 && acc_cyc.size() > 3) ? res_cyc[0] - acc_cyc[3] : -1, 3);

    // All -1 pixels times weight 2: 4 x 9 x (-2) = -72 (0 with ReLU)
    clear_mon();
    run_group(fill(-1), fill(2), 1'b0);
    drain();
    check("t2_count", res_q.size(), 1);
    check("t2_data", first_res(), exp_neg72);

    // Most negative squared: 36 x 65536 = 2359296
    clear_mon();
    run_group(fill(-256), fill(-256), 1'b0);
    drain();
    check("t3_data", first_res(), 2359296);

    // Most negative product: 36 x (255 x -256) = -2350080 (0 with ReLU)
    clear_mon();
    run_group(fill(255), fill(-256), 1'b0);
    drain();
    check("t4_data", first_res(), exp_min);

    // Distinct channels: 204 + 36 - 36 + 54 = 258 (tag 0 load, then adds)
    clear_mon();
    send_beat(ramp(),   ramp());
    send_beat(fill(1),  ramp());
    send_beat(fill(-1), ramp());
    send_beat(fill(2),  fill(3));
    bus.in_valid = 1'b0;
    drain();
    check("t5_count", res_q.size(), 1);
    check("t5_data", first_res(), 258);

    // Back-pressure: 8 beats, out_ready low for 5 cycles of the first result
    clear_mon();
    bus.out_ready = 1'b0;
    fork
      begin
        for (int b = 0; b < 2*CH; b++) send_beat(ramp(), ramp());
        bus.in_valid = 1'b0;
      end
      begin
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.out_valid && n < 100) begin
          @(negedge clk);
          n++;
        end
        if (n >= 100) check("t6_wait_valid", longint'(bus.out_valid), 1);
        repeat (5) @(negedge clk);
        bus.out_ready = 1'b1;
      end
    join
    drain();
    check("t6_count", res_q.size(), 2);
    check("t6_first", first_res(), 816);
    check("t6_second", (res_q.size() > 1) ? res_q[1] : -1, 816);
    check("t6_stall_cycles", stall_cycles, 5);
    check("t6_in_ready_in_stall", ir_err, 0);
    check("t6_stable_in_stall", stable_err, 0);

    // Reset in the middle of a group discards the partial sum and counter
    clear_mon();
    send_beat(ramp(), ramp());
    send_beat(ramp(), ramp());
    bus.in_valid = 1'b0;
    #3;
    rst = 1'b1;
    #1;
    check("t7_rst_out_valid", longint'(bus.out_valid), 0);
    check("t7_rst_out_data",  longint'(bus.out_data), 0);
    check("t7_rst_in_ready",  longint'(bus.in_ready), 1);
    @(negedge clk);
    check("t7_rst_hold_valid", longint'(bus.out_valid), 0);
    rst = 1'b0;
    clear_mon();
    run_group(ramp(), ramp(), 1'b0);
    drain();
    check("t7_count", res_q.size(), 1);
    check("t7_data", first_res(), 816);

    // Idle cycles between beats leave the counter and acc alone
    clear_mon();
    run_group(ramp(), ramp(), 1'b1);
    drain();
    check("t8_count", res_q.size(), 1);
    check("t8_data", first_res(), 816);
    check("t8_valid_cycles", valid_cycles, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/conv_mac_pipe.md
CONV_MAC_PIPE -- requirements
Module: conv_mac_pipe

Interface
REQ-001 Parameter WIDTH, default 9: bit width of each signed two's-complement pixel and weight.
REQ-002 Parameter K, default 3: kernel side; window holds K*K elements.
REQ-003 Parameter CH, default 4: input channels accumulated into one output; CH >= 1.
REQ-004 Parameter ACC_W, default 2*WIDTH+$clog2(K*K*CH): output width, signed.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 in_valid  in  1  window/kernel beat present.
REQ-008 in_ready  out  1  block accepts a beat this cycle.
REQ-009 win  in  K*K*WIDTH  pixel window, element r*K+c at bits [(r*K+c)*WIDTH +: WIDTH].
REQ-010 ker  in  K*K*WIDTH  kernel weights, same packing as win.
REQ-011 out_valid  out  1  out_data holds a completed result.
REQ-012 out_ready  in  1  consumer takes out_data this cycle.
REQ-013 out_data  out  ACC_W  signed sum over CH channels of sum(win[i]*ker[i]).

Function
REQ-014 Beat accepted at a rising edge iff in_valid && in_ready; stall = out_valid && !out_ready; in_ready = !stall, combinational.
REQ-015 Stage 1 registers K*K signed products (2*WIDTH each) of the accepted beat plus a stage-valid and channel tag.
REQ-016 Stage 2 registers the sign-extended sum of stage-1 products at ACC_W bits, carrying valid and tag.
REQ-017 Stage 3: tag 0 loads acc with the stage-2 sum; other tags add it to acc; no intermediate saturation.
REQ-018 Channel counter advances 0..CH-1 per accepted beat, wraps to 0 after CH-1; tag = counter value at acceptance.
REQ-019 When stage 3 processes tag CH-1, the final sum is written to out_data and out_valid set on that edge: latency 3 edges from acceptance of the last channel beat to out_valid high.
REQ-020 All pipeline registers, the counter and acc hold their values while stall is high; bubbles (in_valid low) propagate as invalid stages without touching acc or counter.
REQ-021 out_valid clears on an edge with out_ready high and no new result; new result with out_ready high replaces out_data, out_valid stays 1.
REQ-022 out_data and out_valid never change while stall is high.
REQ-023 CH=1: every accepted beat produces one result, each tag 0.

Reset
REQ-024 rst high clears out_valid, out_data, acc, all stage valids, tags and counter to 0 immediately, independent of clk.
REQ-025 in_ready is 1 during and after reset; a partially accumulated channel group in flight at reset is discarded.
REQ-026 First beat accepted after reset release carries tag 0.

Configuration
REQ-027 Macro CONV_MAC_RELU_EN defined: a negative final sum is written as 0 at REQ-019; non-negative sums unchanged.
REQ-028 Macro CONV_MAC_RELU_EN undefined: final sum written unmodified, signed.

Verification
REQ-029 Defaults, win=ker=0..8 per element, 4 consecutive beats, out_ready=1 -> one result out_data=816 (4x204), out_valid high exactly 1 cycle, 3 edges after 4th acceptance.
REQ-030 win all -1 (9'h1FF), ker all 2, 4 beats -> out_data=-72 without macro; 0 with CONV_MAC_RELU_EN.
REQ-031 win=ker all -256, 4 beats -> out_data=2359296, no overflow in 24 bits.
REQ-032 8 beats back-to-back, out_ready low when first result appears, held 5 cycles -> in_ready low during hold, first result stable, both results 816 in order, none lost.
REQ-033 rst pulsed after 2 beats of a group, then 4 fresh beats of 0..8 -> single result 816, no stale contribution, out_valid 0 during reset.
REQ-034 in_valid toggled every other cycle for 4 beats -> same 816 result, counter unaffected by idle cycles.
